// File: rtl/fft_pkg.sv
// ------------------------------------------------------------------
// fft_pkg : shared types and default sizing for the FFT sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fft_pkg;

    localparam int M_DEF        = 9;
    localparam int BFLY_LAT_DEF = 2;
    localparam int ADR_W_DEF    = M_DEF;
    localparam int TW_W_DEF     = M_DEF - 1;
    localparam int STAGE_W_DEF  = $clog2(M_DEF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fft_adr_gen.sv
// ------------------------------------------------------------------
// fft_adr_gen : butterfly operand and twiddle addresses for (stage, b)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fft_adr_gen
    import fft_pkg::*;
#(
    parameter int M = M_DEF
) (
    input  logic [$clog2(M)-1:0] stage,
    input  logic [M-2:0]         b,
    output logic [M-1:0]         adr_a,
    output logic [M-1:0]         adr_b,
    output logic [M-2:0]         twiddle_adr
);

    localparam logic [M-2:0] C_ONE_B = 1;
    localparam logic [M-1:0] C_ONE_M = 1;

    logic [M-2:0] w_mask;
    logic [M-2:0] w_pos;
    logic [M-2:0] w_hi;

    // At the last stage the mask shift overflows to zero, so mask-1 is all ones
    assign w_mask      = (C_ONE_B << stage) - C_ONE_B;
    assign w_pos       = b & w_mask;
    assign w_hi        = b >> stage;
    assign adr_a       = (M'(w_hi) << (int'(stage) + 1)) | M'(w_pos);
    assign adr_b       = adr_a + (C_ONE_M << stage);
    assign twiddle_adr = w_pos << (M - 1 - int'(stage));

endmodule

`default_nettype wire

// File: rtl/fft_ctrl.sv
// ------------------------------------------------------------------
// fft_ctrl : in-place radix-2 FFT read/write sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fft_ctrl
    import fft_pkg::*;
#(
    parameter int M        = M_DEF,
    parameter int BFLY_LAT = BFLY_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [M-1:0]         radr,
    output logic [M-2:0]         twiddle_adr,
    output logic                 op_sel,
    output logic                 rd_valid,
    output logic                 we,
    output logic [M-1:0]         wadr,
    output logic                 wr_sel,
    output logic [$clog2(M)-1:0] stage
);

    localparam int DEPTH = 2 + BFLY_LAT;
    localparam int SW    = $clog2(M);
    localparam logic [SW-1:0] C_LAST_STAGE = SW'(M - 1);

    state_t         r_state, w_next;
    logic [M-2:0]   r_b;
    logic           r_phase;
    logic [SW-1:0]  r_stage;
    logic           w_rd_en;
    logic           w_last_rd;
    logic           w_last_wr;
    logic [M-1:0]   w_adr_a, w_adr_b;
    logic [M-2:0]   w_tw;

    logic [DEPTH-1:0] r_pipe_vld;
    logic [DEPTH-1:0] r_pipe_sel;
    logic [DEPTH-1:0] r_pipe_last;
    logic [M-1:0]     r_pipe_adr [DEPTH];

    fft_adr_gen #(.M(M)) u_adr_gen (
        .stage       (r_stage),
        .b           (r_b),
        .adr_a       (w_adr_a),
        .adr_b       (w_adr_b),
        .twiddle_adr (w_tw)
    );

    assign w_last_rd = w_rd_en & r_phase & (&r_b);
    assign w_last_wr = r_pipe_vld[DEPTH-1] & r_pipe_last[DEPTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        w_rd_en = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_READ;
            S_READ: begin
                busy    = 1'b1;
                w_rd_en = 1'b1;
                if (w_last_rd) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_last_wr) w_next = (r_stage == C_LAST_STAGE) ? S_FINISH : S_READ;
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // b wraps to zero naturally after the last B read of a stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_b     <= '0;
            r_phase <= 1'b0;
            r_stage <= '0;
        end else if (r_state == S_IDLE || r_state == S_FINISH) begin
            r_b     <= '0;
            r_phase <= 1'b0;
            r_stage <= '0;
        end else if (r_state == S_READ) begin
            r_phase <= ~r_phase;
            if (r_phase) r_b <= r_b + 1'b1;
        end else if (w_last_wr && r_stage != C_LAST_STAGE) begin
            r_stage <= r_stage + SW'(1);
        end
    end

    assign radr        = w_rd_en ? (r_phase ? w_adr_b : w_adr_a) : '0;
    assign twiddle_adr = (w_rd_en & r_phase) ? w_tw : '0;

    // Read addresses ride a delay line and re-emerge as write addresses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_vld  <= '0;
            r_pipe_sel  <= '0;
            r_pipe_last <= '0;
            for (int i = 0; i < DEPTH; i++) r_pipe_adr[i] <= '0;
        end else begin
            r_pipe_vld    <= {r_pipe_vld[DEPTH-2:0],  w_rd_en};
            r_pipe_sel    <= {r_pipe_sel[DEPTH-2:0],  w_rd_en & r_phase};
            r_pipe_last   <= {r_pipe_last[DEPTH-2:0], w_last_rd};
            r_pipe_adr[0] <= radr;
            for (int i = 1; i < DEPTH; i++) r_pipe_adr[i] <= r_pipe_adr[i-1];
        end
    end

    assign rd_valid = r_pipe_vld[0];
    assign op_sel   = r_pipe_sel[0];
    assign we       = r_pipe_vld[DEPTH-1];
    assign wr_sel   = r_pipe_sel[DEPTH-1];
    assign wadr     = r_pipe_adr[DEPTH-1];
    assign stage    = r_stage;

endmodule

`default_nettype wire

// File: tb/tb_fft_ctrl.sv
// ------------------------------------------------------------------
// tb_fft_ctrl : schedule-model checker for fft_ctrl (M=3, BFLY_LAT=2)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fft_ctrl;

    localparam int M    = 3;
    localparam int BL   = 2;
    localparam int N    = 8;
    localparam int P    = N + 2 + BL;
    localparam int LAST = M * P;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, op_sel, rd_valid, we, wr_sel;
    logic [2:0] radr, wadr;
    logic [1:0] twiddle_adr;
    logic [1:0] stage;

    fft_ctrl #(.M(M), .BFLY_LAT(BL)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .radr        (radr),
        .twiddle_adr (twiddle_adr),
        .op_sel      (op_sel),
        .rd_valid    (rd_valid),
        .we          (we),
        .wadr        (wadr),
        .wr_sel      (wr_sel),
        .stage       (stage)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_active = 1'b0;
    int t0 = 0;
    int first_we, first_wadr, first_wrsel, last_we, last_wadr, done_at;
    int rd_log[$];
    int tw_log[$];

    int lit_radr [24] = '{0,1,2,3,4,5,6,7, 0,2,1,3,4,6,5,7, 0,4,1,5,2,6,3,7};
    int lit_tw   [12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};

    // Address of the k-th read slot of stage s (even k: A, odd k: B)
    function automatic int adr_of(int s, int k);
        int b, half, a;
        b    = k / 2;
        half = 1 << s;
        a    = (b / half) * 2 * half + (b % half);
        return (k % 2 == 1) ? a + half : a;
    endfunction

    function automatic int tw_of(int s, int k);
        int b;
        b = k / 2;
        return (b % (1 << s)) * (1 << (M - 1 - s));
    endfunction

    function automatic bit is_rd(int t);
        return (t >= 1) && (t <= LAST) && (((t - 1) % P) < N);
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        rd_log.delete();
        tw_log.delete();
        first_we = -1; first_wadr = -1; first_wrsel = -1;
        last_we = -1; last_wadr = -1; done_at = -1;
    endtask

    // Per-cycle comparison against the read/write schedule
    always @(negedge clk) begin
        int t, s, k;
        logic e_busy, e_done, e_rdv, e_ops, e_we, e_wrs;
        logic [2:0] e_radr, e_wadr;
        logic [1:0] e_tw, e_stage, a_stage;
        logic [15:0] exp_v, act_v;
        t = run_active ? (cyc - t0) : -100;
        e_busy = (t >= 1) && (t <= LAST);
        e_done = (t == LAST + 1);
        e_radr = 3'd0; e_tw = 2'd0; e_rdv = 1'b0; e_ops = 1'b0;
        e_we = 1'b0; e_wadr = 3'd0; e_wrs = 1'b0;
        e_stage = e_busy ? 2'((t - 1) / P) : 2'd0;
        a_stage = e_busy ? stage : 2'd0;
        if (is_rd(t)) begin
            s = (t - 1) / P; k = (t - 1) % P;
            e_radr = 3'(adr_of(s, k));
            if (k % 2 == 1) e_tw = 2'(tw_of(s, k));
        end
        if (is_rd(t - 1)) begin
            e_rdv = 1'b1;
            e_ops = 1'(((t - 2) % P) % 2);
        end
        if (is_rd(t - 2 - BL)) begin
            s = (t - 3 - BL) / P; k = (t - 3 - BL) % P;
            e_we = 1'b1;
            e_wadr = 3'(adr_of(s, k));
            e_wrs = 1'(k % 2);
        end
        exp_v = {e_busy, e_done, e_rdv, e_ops, e_we, e_wrs, e_radr, e_tw, e_wadr, e_stage};
        act_v = {busy, done, rd_valid, op_sel, we, wr_sel, radr, twiddle_adr, wadr, a_stage};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle t=%0d {busy,done,rdv,opsel,we,wrsel,radr,tw,wadr,stage}: got %b, expected %b",
                     t, act_v, exp_v);
        end
        if (run_active) begin
            if (is_rd(t)) begin
                rd_log.push_back(int'(radr));
                if (((t - 1) % P) % 2 == 1) tw_log.push_back(int'(twiddle_adr));
            end
            if (we === 1'b1) begin
                if (first_we < 0) begin
                    first_we = t; first_wadr = int'(wadr); first_wrsel = int'(wr_sel);
                end
                last_we = t; last_wadr = int'(wadr);
            end
            if (done === 1'b1 && done_at < 0) done_at = t;
        end
    end

    task automatic do_start();
        @(negedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        run_active = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_run_literals();
        check_int("radr count", rd_log.size(), 24);
        for (int i = 0; i < 24 && i < rd_log.size(); i++)
            check_int($sformatf("radr[%0d]", i), rd_log[i], lit_radr[i]);
        check_int("twiddle count", tw_log.size(), 12);
        for (int i = 0; i < 12 && i < tw_log.size(); i++)
            check_int($sformatf("twiddle[%0d]", i), tw_log[i], lit_tw[i]);
        check_int("first we cycle", first_we, 5);
        check_int("first wadr", first_wadr, 0);
        check_int("first wr_sel", first_wrsel, 0);
        check_int("last we cycle", last_we, 36);
        check_int("last wadr", last_wadr, 7);
        check_int("done cycle", done_at, 37);
    endtask

    initial begin
        clear_log();
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (20) @(negedge clk);

        // Plain run
        clear_log();
        do_start();
        repeat (42) @(negedge clk);
        check_run_literals();

        // Start pulse mid-run must be ignored
        clear_log();
        do_start();
        repeat (9) @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        repeat (32) @(negedge clk);
        check_int("done cycle with mid-run start", done_at, 37);
        check_int("last we with mid-run start", last_we, 36);

        // Abort by reset at cycle 15
        clear_log();
        do_start();
        repeat (14) @(negedge clk);
        #1 reset = 1'b0;
        run_active = 1'b0;
        #1;
        check_int("we under reset", int'(we), 0);
        check_int("busy under reset", int'(busy), 0);
        check_int("radr under reset", int'(radr), 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        repeat (5) @(negedge clk);

        // Re-run after abort
        clear_log();
        do_start();
        repeat (42) @(negedge clk);
        check_run_literals();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter M, default 9: log2 of FFT size N = 2**M; RAM address width.
REQ-002 Parameter BFLY_LAT, default 2: cycles from B-operand/twiddle data valid to butterfly result A' valid.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to run one full in-place FFT on the RAM contents.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 done  output  1  one-cycle pulse when all stages are written back.
REQ-008 radr  output  M  RAM read address.
REQ-009 twiddle_adr  output  M-1  twiddle ROM address.
REQ-010 op_sel  output  1  0: RAM rd carries operand A this cycle; 1: carries B. Valid only when rd_valid is high.
REQ-011 rd_valid  output  1  RAM rd holds a live operand this cycle.
REQ-012 we  output  1  RAM write enable.
REQ-013 wadr  output  M  RAM write address.
REQ-014 wr_sel  output  1  0: write butterfly output A'; 1: write B'.
REQ-015 stage  output  $clog2(M)  current stage index, 0..M-1.

Function
REQ-016 States: IDLE, READ, DRAIN, FINISH. IDLE->READ on start; READ->DRAIN after last B read of a stage; DRAIN->READ (stage+1) or DRAIN->FINISH (stage M-1) after last write of that stage; FINISH->IDLE after one cycle.
REQ-017 start is sampled only in IDLE; start while busy is ignored.
REQ-018 Butterfly counter b runs 0..N/2-1 per stage; each butterfly occupies two READ cycles: A address then B address.
REQ-019 For stage s: half = 2**s, pos = b mod half, adrA = (b>>s)*2*half + pos, adrB = adrA + half, twiddle_adr = pos << (M-1-s). All arithmetic is unsigned and truncated to M bits.
REQ-020 twiddle_adr is issued with the B read, so that ROM data aligns with B data.
REQ-021 RAM and ROM have 1-cycle read latency. rd_valid/op_sel are the one-cycle-delayed read strobe and selector.
REQ-022 A read issued at cycle t: we=1, wadr=adrA, wr_sel=0 at t+2+BFLY_LAT; we=1, wadr=adrB, wr_sel=1 at t+3+BFLY_LAT.
REQ-023 Write addresses come from a delay line of depth 2+BFLY_LAT; they are never recomputed.
REQ-024 First read of stage s+1 is issued the cycle after the last write of stage s. Stage period P = N+2+BFLY_LAT cycles.
REQ-025 Start accepted at cycle 0: first read at cycle 1, last write at cycle M*P, and done=1 at cycle M*P+1. busy=1 on cycles 1..M*P.
REQ-026 we is never asserted in IDLE or FINISH. Read and write addresses of the same stage never coincide in the same cycle.
REQ-027 done and busy are mutually exclusive.

Reset
REQ-028 Asserting reset forces state=IDLE; b, stage and the delay line clear; busy=0, done=0, we=0, rd_valid=0, op_sel=0, wr_sel=0, radr=0, wadr=0, twiddle_adr=0.
REQ-029 Reset mid-run aborts with no further writes. The RAM contents are then undefined; the next start re-runs from stage 0.

Structure
REQ-030 Package fft_pkg holds the state enum, default M and BFLY_LAT, and the address-width localparams.
REQ-031 Sub-module fft_adr_gen (combinational: stage, b -> adrA, adrB, twiddle_adr). The delay line and FSM live in fft_ctrl.

Verification (M=3, BFLY_LAT=2, N=8, P=12)
REQ-032 Reset held, then released, with start=0 -> all outputs 0 and state IDLE for 20 cycles.
REQ-033 start at cycle 0 -> radr sequence stage 0: 0,1,2,3,4,5,6,7. Stage 1: 0,2,1,3,4,6,5,7. Stage 2: 0,4,1,5,2,6,3,7.
REQ-034 Same run, twiddle_adr on B cycles -> stage 0: 0,0,0,0; stage 1: 0,2,0,2; stage 2: 0,1,2,3.
REQ-035 Same run -> first we at cycle 5 with wadr=0 and wr_sel=0; last we at cycle 36 with wadr=7; done=1 only at cycle 37; busy=1 on cycles 1..36.
REQ-036 start pulsed at cycle 10 during a run -> no effect; done still at cycle 37 only.
REQ-037 reset asserted at cycle 15 -> we=0 immediately and state IDLE. A new start after release reproduces REQ-033..035 relative to the new start.
